forex_sched: RTL and testbench
==============================

# forex_sched

Scheduler that owns the adjacency/vertex memories around the Bellman-Ford engine. It buffers incoming price-edge updates in a small FIFO and drains them into adjmat while the engine is idle. On host request it launches a Bellman pass from a chosen source vertex, holds the memories for the engine until `bellman_done`, then presents the result to the host. Sits between the host/Avalon update path and the `Bellman` instance; the top level muxes memory ports on `mem_owner`.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: update FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 65536: watchdog limit; used only with `SCHED_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `upd_valid` in 1 / `upd_ready` out 1: update handshake; transfer on a cycle with both high.
- `upd_row`, `upd_col` in `PRED_WIDTH+1`: edge endpoints.
- `upd_weight` in `WEIGHT_WIDTH+1`: signed edge weight (0 = no edge).
- `run_req` in 1: one-cycle pulse requesting a Bellman pass. `run_src` in `PRED_WIDTH+1`: source vertex, sampled with `run_req`.
- `adj_we` out 1; `adj_wr_row`, `adj_wr_col` out `PRED_WIDTH+1`; `adj_wr_data` out `WEIGHT_WIDTH+1`: adjmat write port.
- `mem_owner` out 1: 0 = scheduler/host, 1 = Bellman engine.
- `bellman_reset` out 1; `bellman_src` out `PRED_WIDTH+1`; `bellman_done` in 1.
- `res_valid` out 1 / `res_ack` in 1: pass complete, vertmat readable by host.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: watchdog fired (constant 0 without macro).

## Operation
- FIFO: `upd_ready = !full`, combinational. A push is accepted in every state, including RUN and REPORT. When full, no push occurs even if a pop happens in the same cycle. Pointers wrap modulo `FIFO_DEPTH`. Count width is `$clog2(FIFO_DEPTH)+1`.
- Run request:
  - `run_req` sets `run_pend` and latches `run_src` into `src_q`, in any state.
  - A repeat request while pending overwrites `src_q`; only one pass runs.
  - `run_pend` clears on entry to START.
- States:
  - IDLE: if the FIFO is non-empty, go to DRAIN. Otherwise, if `run_pend` is set, go to START.
  - DRAIN: each cycle, pop the head and drive `adj_we=1` with the head fields in the same cycle. Go to IDLE when the FIFO becomes empty. If `run_pend` is set and `drain_cnt` reaches `FIFO_DEPTH`, go to START. This is the anti-starvation rule. `drain_cnt` resets on DRAIN entry.
  - START: `bellman_reset=1`, `mem_owner=1`, `bellman_src=src_q`. Lasts one cycle, then go to RUN.
  - RUN: `mem_owner=1`. `bellman_done` is sampled only here. On done, go to REPORT.
  - REPORT: `res_valid=1`, `mem_owner=0`, no draining. On `res_ack`, go to IDLE.
- `bellman_src` holds `src_q` in all states. `adj_*` outputs are 0 when `adj_we=0`.
- Reset values: state IDLE, FIFO empty, `upd_ready=1`. `adj_we`, `mem_owner`, `bellman_reset`, `res_valid`, `busy`, `timeout_err` and `run_pend` all 0. `bellman_src=0`.
- Reset mid-RUN: return to IDLE with `mem_owner=0` on the next cycle. The engine is not reset by this block until the next START.

## Timing
- Update accepted at edge N: the earliest `adj_we` for it is in cycle N+2 (IDLE at N+1, DRAIN at N+2) when the block is idle and the FIFO was empty.
- `run_req` at edge N, block idle, FIFO empty: `bellman_reset` is high in cycle N+2 only.
- `bellman_done` high in RUN at edge M: `res_valid` is high from cycle M+1.
- `res_ack` at edge R: IDLE at R+1. Drain resumes at R+2.
- Throughput: one adjmat write per cycle in DRAIN.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A counter runs in RUN.
  - If it reaches `TIMEOUT_CYCLES` without `bellman_done`: go to IDLE, set `mem_owner=0`, set `timeout_err=1`, and do not assert `res_valid`.
  - `timeout_err` stays high until `reset` or the next START.
- `SCHED_TIMEOUT_EN` undefined: no counter; RUN waits indefinitely; `timeout_err` is tied to 0.

## Test plan
- Reset, then push 3 updates (row 1, col 2, weight -5; row 2, col 3, weight 7; row 3, col 1, weight 4) → exactly three `adj_we` cycles in push order, beginning 2 cycles after the first acceptance; FIFO empty afterwards.
- `run_req` with `run_src`=2 while idle → `bellman_reset` high for exactly one cycle with `bellman_src`=2; `mem_owner`=1 through RUN; `bellman_done` → `res_valid`; `res_ack` → IDLE.
- During RUN push 9 updates with `FIFO_DEPTH`=8 → `upd_ready` drops after 8; no `adj_we` until after `res_ack`; then 8 sequential writes.
- Continuous `upd_valid` with `run_req` pending → START reached after exactly 8 DRAIN writes.
- `run_req` src=1 then src=4 before START → one pass with `bellman_src`=4.
- Macro on, `TIMEOUT_CYCLES`=16, `bellman_done` never asserted → `timeout_err`=1 at RUN cycle 16, IDLE, `res_valid` stays 0; reset asserted mid-RUN → IDLE with all outputs at their reset values.

Source files
------------

// File: rtl/forex_sched.sv
// forex_sched: owns the adjmat/vertmat ports around the Bellman-Ford engine.
// Buffers price-edge updates in a small FIFO and drains them into adjmat
// while the engine is idle. Launches a Bellman pass on host request, hands
// the memories to the engine until bellman_done, then presents the result.
// Optional feature macro: SCHED_TIMEOUT_EN adds a RUN watchdog that drives
// timeout_err; without it timeout_err is constant 0.
module forex_sched #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int PRED_WIDTH     = 3,
   parameter int WEIGHT_WIDTH   = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [PRED_WIDTH:0]     upd_row,
   input  logic [PRED_WIDTH:0]     upd_col,
   input  logic [WEIGHT_WIDTH:0]   upd_weight,
   input  logic                    run_req,
   input  logic [PRED_WIDTH:0]     run_src,
   output logic                    adj_we,
   output logic [PRED_WIDTH:0]     adj_wr_row,
   output logic [PRED_WIDTH:0]     adj_wr_col,
   output logic [WEIGHT_WIDTH:0]   adj_wr_data,
   output logic                    mem_owner,
   output logic                    bellman_reset,
   output logic [PRED_WIDTH:0]     bellman_src,
   input  logic                    bellman_done,
   output logic                    res_valid,
   input  logic                    res_ack,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_START,
      S_RUN,
      S_REPORT
   } state_t;

   state_t state;
   state_t next_state;

   logic [PRED_WIDTH:0]   row_mem [FIFO_DEPTH];
   logic [PRED_WIDTH:0]   col_mem [FIFO_DEPTH];
   logic [WEIGHT_WIDTH:0] wt_mem  [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] drain_cnt;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             run_pend;
   logic [PRED_WIDTH:0] src_q;
   logic             timeout_hit;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign upd_ready = !full;
   assign push      = upd_valid && !full;
   assign pop       = (state == S_DRAIN) && !empty;

   assign adj_wr_row  = adj_we ? row_mem[rd_ptr] : '0;
   assign adj_wr_col  = adj_we ? col_mem[rd_ptr] : '0;
   assign adj_wr_data = adj_we ? wt_mem[rd_ptr]  : '0;
   assign bellman_src = src_q;

   // FIFO storage: written on every accepted update, never reset
   always_ff @(posedge clk) begin
      if (push) begin
         row_mem[wr_ptr] <= upd_row;
         col_mem[wr_ptr] <= upd_col;
         wt_mem[wr_ptr]  <= upd_weight;
      end
   end

   // Occupancy after this cycle's push/pop, used to leave DRAIN once empty
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // FIFO pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
      end
   end

   // Writes made in the current DRAIN visit, saturating so a late run request
   // still gets through after the next write
   always_ff @(posedge clk) begin
      if (reset || state != S_DRAIN) begin
         drain_cnt <= '0;
      end else if (pop && drain_cnt != CNT_W'(FIFO_DEPTH)) begin
         drain_cnt <= drain_cnt + CNT_W'(1);
      end
   end

   // Pending run request; a new request wins over the clear on START entry
   always_ff @(posedge clk) begin
      if (reset) begin
         run_pend <= 1'b0;
         src_q    <= '0;
      end else begin
         if (next_state == S_START && state != S_START) run_pend <= 1'b0;
         if (run_req) begin
            run_pend <= 1'b1;
            src_q    <= run_src;
         end
      end
   end

`ifdef SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TO_W-1:0] run_cnt;
   logic            timeout_q;

   assign timeout_hit = (state == S_RUN) && !bellman_done &&
                        (run_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = timeout_q;

   // Cycles spent in the current RUN visit
   always_ff @(posedge clk) begin
      if (reset || state != S_RUN) run_cnt <= '0;
      else                         run_cnt <= run_cnt + TO_W'(1);
   end

   // Sticky watchdog flag, cleared when the next pass starts
   always_ff @(posedge clk) begin
      if (reset)                                           timeout_q <= 1'b0;
      else if (next_state == S_START && state != S_START)  timeout_q <= 1'b0;
      else if (timeout_hit)                                timeout_q <= 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
   // Constant 0; expressed against the limit so the parameter stays referenced
   assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic: draining has priority in IDLE, bounded by anti-starvation
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (!empty)        next_state = S_DRAIN;
            else if (run_pend) next_state = S_START;
         end
         S_DRAIN: begin
            if (run_pend && drain_cnt >= CNT_W'(FIFO_DEPTH - 1)) next_state = S_START;
            else if (count_next == '0)                           next_state = S_IDLE;
         end
         S_START:  next_state = S_RUN;
         S_RUN: begin
            if (bellman_done)     next_state = S_REPORT;
            else if (timeout_hit) next_state = S_IDLE;
         end
         S_REPORT: begin
            if (res_ack) next_state = S_IDLE;
         end
         default:  next_state = S_IDLE;
      endcase
   end

   // Per-state outputs
   always_comb begin
      adj_we        = 1'b0;
      mem_owner     = 1'b0;
      bellman_reset = 1'b0;
      res_valid     = 1'b0;
      busy          = (state != S_IDLE);
      case (state)
         S_DRAIN:  adj_we = pop;
         S_START: begin
            mem_owner     = 1'b1;
            bellman_reset = 1'b1;
         end
         S_RUN:    mem_owner = 1'b1;
         S_REPORT: res_valid = 1'b1;
         default: begin
            adj_we = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_forex_sched.sv
// Testbench for forex_sched: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_forex_sched;

   localparam int DEPTH = 8;
   localparam int TMO   = 16;
   localparam int PW    = 3;
   localparam int WW    = 15;
   localparam logic [63:0] RESET_VEC = 64'h4_0000_0000;

   localparam int P_IDLE   = 0;
   localparam int P_DRAIN  = 1;
   localparam int P_START  = 2;
   localparam int P_RUN    = 3;
   localparam int P_REPORT = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          upd_valid;
   logic          upd_ready;
   logic [PW:0]   upd_row;
   logic [PW:0]   upd_col;
   logic [WW:0]   upd_weight;
   logic          run_req;
   logic [PW:0]   run_src;
   logic          adj_we;
   logic [PW:0]   adj_wr_row;
   logic [PW:0]   adj_wr_col;
   logic [WW:0]   adj_wr_data;
   logic          mem_owner;
   logic          bellman_reset;
   logic [PW:0]   bellman_src;
   logic          bellman_done;
   logic          res_valid;
   logic          res_ack;
   logic          busy;
   logic          timeout_err;

   always #5 clk = ~clk;

   forex_sched #(
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TMO),
      .PRED_WIDTH(PW),
      .WEIGHT_WIDTH(WW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .upd_valid(upd_valid),
      .upd_ready(upd_ready),
      .upd_row(upd_row),
      .upd_col(upd_col),
      .upd_weight(upd_weight),
      .run_req(run_req),
      .run_src(run_src),
      .adj_we(adj_we),
      .adj_wr_row(adj_wr_row),
      .adj_wr_col(adj_wr_col),
      .adj_wr_data(adj_wr_data),
      .mem_owner(mem_owner),
      .bellman_reset(bellman_reset),
      .bellman_src(bellman_src),
      .bellman_done(bellman_done),
      .res_valid(res_valid),
      .res_ack(res_ack),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic [PW:0] row;
      logic [PW:0] col;
      logic [WW:0] w;
   } upd_t;

   int total = 0;
   int bad   = 0;

   upd_t        mq[$];
   int          ph;
   bit          pend;
   logic [PW:0] msrc;
   bit          terr;
   int          dcnt;
   int          tcnt;

   bit    armed = 1'b0;
   int    cyc = 0;
   upd_t  obs_wr[$];
   int    first_wr_cyc;
   int    brst_cycles;
   logic [PW:0] brst_src;
   int    wr_at_brst;
   bit    terr_seen;
   bit    rv_seen;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
      end
   endtask

   function automatic logic [63:0] expectedOut();
      logic [PW:0] r;
      logic [PW:0] c;
      logic [WW:0] w;
      r = '0;
      c = '0;
      w = '0;
      if (ph == P_DRAIN) begin
         r = mq[0].row;
         c = mq[0].col;
         w = mq[0].w;
      end
      return {29'b0, mq.size() < DEPTH, ph == P_DRAIN, r, c, w,
              (ph == P_START) || (ph == P_RUN), ph == P_START, msrc,
              ph == P_REPORT, ph != P_IDLE, terr};
   endfunction

   function automatic logic [63:0] observedOut();
      return {29'b0, upd_ready, adj_we, adj_wr_row, adj_wr_col, adj_wr_data,
              mem_owner, bellman_reset, bellman_src, res_valid, busy, timeout_err};
   endfunction

   // Reference behaviour for one clock edge with the given inputs
   task automatic modelStep(input logic v, input logic [PW:0] r, input logic [PW:0] c,
                            input logic [WW:0] w, input logic rq, input logic [PW:0] s,
                            input logic dn, input logic ak, input logic rs);
      bit   push;
      bit   pop;
      int   nph;
      upd_t e;
      if (rs) begin
         mq.delete();
         ph = P_IDLE; pend = 0; msrc = '0; terr = 0; dcnt = 0; tcnt = 0;
         return;
      end
      push = v && (mq.size() < DEPTH);
      pop  = (ph == P_DRAIN);
      nph  = ph;
      case (ph)
         P_IDLE: begin
            if (mq.size() != 0) begin nph = P_DRAIN; dcnt = 0; end
            else if (pend) nph = P_START;
         end
         P_DRAIN: begin
            if (dcnt < DEPTH) dcnt++;
            if (pend && dcnt >= DEPTH) nph = P_START;
            else if (mq.size() - 1 + int'(push) == 0) nph = P_IDLE;
         end
         P_START: begin nph = P_RUN; tcnt = 0; end
         P_RUN: begin
            if (dn) nph = P_REPORT;
`ifdef SCHED_TIMEOUT_EN
            else begin
               tcnt++;
               if (tcnt >= TMO) begin nph = P_IDLE; terr = 1; end
            end
`endif
         end
         P_REPORT: if (ak) nph = P_IDLE;
         default: nph = P_IDLE;
      endcase
      if (nph == P_START) begin pend = 0; terr = 0; end
      if (rq) begin pend = 1; msrc = s; end
      if (pop) void'(mq.pop_front());
      if (push) begin
         e.row = r; e.col = c; e.w = w;
         mq.push_back(e);
      end
      ph = nph;
   endtask

   // One clock: check current outputs, drive inputs, advance the model
   task automatic applyStimulus(input logic v, input logic [PW:0] r, input logic [PW:0] c,
                                input logic [WW:0] w, input logic rq, input logic [PW:0] s,
                                input logic dn, input logic ak, input logic rs);
      upd_t e;
      @(negedge clk);
      if (armed) begin
         checkOutput("outputs", observedOut(), expectedOut());
         if (adj_we) begin
            e.row = adj_wr_row; e.col = adj_wr_col; e.w = adj_wr_data;
            obs_wr.push_back(e);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
         end
         if (bellman_reset) begin
            brst_cycles++;
            brst_src = bellman_src;
            if (wr_at_brst < 0) wr_at_brst = obs_wr.size();
         end
         if (timeout_err) terr_seen = 1;
         if (res_valid) rv_seen = 1;
      end
      upd_valid = v; upd_row = r; upd_col = c; upd_weight = w;
      run_req = rq; run_src = s; bellman_done = dn; res_ack = ak; reset = rs;
      @(posedge clk);
      modelStep(v, r, c, w, rq, s, dn, ak, rs);
      armed = 1'b1;
      cyc++;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic clearLog();
      obs_wr.delete();
      first_wr_cyc = -1;
      brst_cycles  = 0;
      brst_src     = '0;
      wr_at_brst   = -1;
      terr_seen    = 0;
      rv_seen      = 0;
   endtask

   initial begin
      int push_cyc;
      clearLog();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("reset_vals", observedOut(), RESET_VEC);
      idleCycles(2);

      // Three updates drained in order, first write two cycles after acceptance
      clearLog();
      push_cyc = cyc;
      applyStimulus(1, 1, 2, (WW+1)'(-5), 0, 0, 0, 0, 0);
      applyStimulus(1, 2, 3, (WW+1)'(7), 0, 0, 0, 0, 0);
      applyStimulus(1, 3, 1, (WW+1)'(4), 0, 0, 0, 0, 0);
      idleCycles(6);
      checkOutput("t1_write_count", obs_wr.size(), 3);
      checkOutput("t1_first_latency", first_wr_cyc - push_cyc, 2);
      if (obs_wr.size() == 3) begin
         checkOutput("t1_w0", {obs_wr[0].row, obs_wr[0].col, obs_wr[0].w}, {4'd1, 4'd2, 16'hFFFB});
         checkOutput("t1_w1", {obs_wr[1].row, obs_wr[1].col, obs_wr[1].w}, {4'd2, 4'd3, 16'd7});
         checkOutput("t1_w2", {obs_wr[2].row, obs_wr[2].col, obs_wr[2].w}, {4'd3, 4'd1, 16'd4});
      end

      // Single pass from source 2
      clearLog();
      applyStimulus(0, 0, 0, 0, 1, 2, 0, 0, 0);
      idleCycles(3);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      idleCycles(2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idleCycles(2);
      checkOutput("t2_brst_cycles", brst_cycles, 1);
      checkOutput("t2_src", brst_src, 2);
      checkOutput("t2_res_valid_seen", rv_seen, 1);

      // Nine pushes during RUN: eight held until after the ack
      clearLog();
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
      idleCycles(1);
      for (int i = 0; i < 9; i++)
         applyStimulus(1, (PW+1)'(i), (PW+1)'(i + 1), (WW+1)'(100 + i), 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      idleCycles(2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("t3_no_write_before_ack", obs_wr.size(), 0);
      idleCycles(12);
      checkOutput("t3_write_count", obs_wr.size(), 8);
      for (int i = 0; i < 8 && i < obs_wr.size(); i++)
         checkOutput("t3_write_row", obs_wr[i].row, i);

      // Continuous updates with a pending run: START after eight writes
      clearLog();
      applyStimulus(1, 5, 6, 1, 1, 3, 0, 0, 0);
      for (int i = 0; i < 13; i++)
         applyStimulus(1, (PW+1)'(i), 7, (WW+1)'(i), 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idleCycles(15);
      checkOutput("t4_writes_before_start", wr_at_brst, 8);

      // Two requests before START: one pass with the later source
      clearLog();
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 2, 2, 2, 1, 1, 0, 0, 0);
      applyStimulus(1, 3, 3, 3, 1, 4, 0, 0, 0);
      idleCycles(6);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      idleCycles(2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idleCycles(3);
      checkOutput("t5_brst_cycles", brst_cycles, 1);
      checkOutput("t5_src", brst_src, 4);

`ifdef SCHED_TIMEOUT_EN
      // Engine never finishes: watchdog returns to IDLE without a result
      clearLog();
      applyStimulus(0, 0, 0, 0, 1, 6, 0, 0, 0);
      idleCycles(22);
      checkOutput("t6_timeout_flag", terr_seen, 1);
      checkOutput("t6_no_result", rv_seen, 0);
`endif

      // Reset while the engine owns the memories
      applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0);
      idleCycles(4);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("mid_run_reset", observedOut(), RESET_VEC);
      idleCycles(2);

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++)
         applyStimulus($urandom_range(0, 1), (PW+1)'($urandom), (PW+1)'($urandom),
                       (WW+1)'($urandom), $urandom_range(0, 19) == 0, (PW+1)'($urandom),
                       $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 299) == 0);
      idleCycles(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
